pipe_skid_stage: RTL

Parametrised pipeline stage register with valid/ready handshake, a two-entry skid buffer and synchronous flush. It replaces the fixed-field, always-advance inter-stage registers (F/D, D/E, E/M, M/W) of the pipelined CPU. It can stall upstream without losing data and squash its contents on a branch or exception. Payload is an opaque bundle: PC, instruction, write-back address, write-back value, packed by the instantiating stage.

---
 rtl/pipe_pkg.sv | 38 +++
 rtl/pipe_slot.sv | 35 +++
 rtl/pipe_skid_stage.sv | 138 +++++++++++++
 3 files changed

// File: rtl/pipe_pkg.sv
// Shared definitions for the inter-stage pipeline registers: occupancy state,
// default payload width and the payload field layout used by every stage.
package pipe_pkg;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2
  } pipe_state_e;

  localparam int PIPE_PAYLOAD_W = 101;

  // Payload layout, MSB to LSB: PC | instr | WB addr | WB value
  localparam int PIPE_WBV_LSB   = 0;
  localparam int PIPE_WBV_W     = 32;
  localparam int PIPE_WBA_LSB   = PIPE_WBV_LSB + PIPE_WBV_W;
  localparam int PIPE_WBA_W     = 5;
  localparam int PIPE_INSTR_LSB = PIPE_WBA_LSB + PIPE_WBA_W;
  localparam int PIPE_INSTR_W   = 32;
  localparam int PIPE_PC_LSB    = PIPE_INSTR_LSB + PIPE_INSTR_W;
  localparam int PIPE_PC_W      = 32;

  function automatic logic [PIPE_PAYLOAD_W-1:0] pipe_pack(
    input logic [PIPE_PC_W-1:0]    pc,
    input logic [PIPE_INSTR_W-1:0] instr,
    input logic [PIPE_WBA_W-1:0]   wb_addr,
    input logic [PIPE_WBV_W-1:0]   wb_val
  );
    logic [PIPE_PAYLOAD_W-1:0] p;
    p = '0;
    p[PIPE_PC_LSB    +: PIPE_PC_W]    = pc;
    p[PIPE_INSTR_LSB +: PIPE_INSTR_W] = instr;
    p[PIPE_WBA_LSB   +: PIPE_WBA_W]   = wb_addr;
    p[PIPE_WBV_LSB   +: PIPE_WBV_W]   = wb_val;
    return p;
  endfunction

endpackage

// File: rtl/pipe_slot.sv
// One payload register plus valid bit. Clear (or reset) loads BUBBLE and
// drops valid; load captures new data; otherwise the slot holds.
module pipe_slot
  import pipe_pkg::*;
#(
  parameter int              W      = PIPE_PAYLOAD_W,
  parameter logic [W-1:0]    BUBBLE = '0
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         i_load,
  input  logic         i_clear,
  input  logic [W-1:0] i_data,
  output logic [W-1:0] o_data,
  output logic         o_valid
);

  logic [W-1:0] r_data;
  logic         r_valid;

  // Clear has priority over load so a flush always squashes the slot
  always_ff @(posedge clk) begin
    if (reset || i_clear) begin
      r_data  <= BUBBLE;
      r_valid <= 1'b0;
    end else if (i_load) begin
      r_data  <= i_data;
      r_valid <= 1'b1;
    end
  end

  assign o_data  = r_data;
  assign o_valid = r_valid;

endmodule

// File: rtl/pipe_skid_stage.sv
// Pipeline stage register with valid/ready handshake and a two-entry skid
// buffer. The main slot always drives the outputs; the skid slot absorbs the
// one extra beat that can arrive after downstream stalls, since in_ready is
// registered and reacts a cycle late.
//
//   state    | meaning
//   ST_EMPTY | no entry held, outputs show BUBBLE
//   ST_ONE   | main slot valid, skid empty
//   ST_FULL  | main and skid valid, upstream stalled
module pipe_skid_stage
  import pipe_pkg::*;
#(
  parameter int                    PAYLOAD_W = PIPE_PAYLOAD_W,
  parameter logic [PAYLOAD_W-1:0]  BUBBLE    = '0
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 flush,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [PAYLOAD_W-1:0] in_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [PAYLOAD_W-1:0] out_data,
  output logic [1:0]           count
);

  pipe_state_e r_state;
  pipe_state_e w_state_nxt;
  logic        r_in_ready;

  logic                 w_push;
  logic                 w_pop;
  logic                 w_main_load;
  logic                 w_main_clear;
  logic                 w_main_sel_skid;
  logic                 w_skid_load;
  logic                 w_skid_clear;
  logic [PAYLOAD_W-1:0] w_main_din;
  logic [PAYLOAD_W-1:0] w_main_data;
  logic [PAYLOAD_W-1:0] w_skid_data;
  logic                 w_main_valid;
  logic                 w_skid_valid;

  assign w_push = in_valid & r_in_ready;
  assign w_pop  = w_main_valid & out_ready;

  // State and in_ready registers; in_ready looks at the next state so it
  // drops in the first FULL cycle and rises in the first cycle after leaving
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= ST_EMPTY;
      r_in_ready <= 1'b1;
    end else begin
      r_state    <= w_state_nxt;
      r_in_ready <= (w_state_nxt != ST_FULL);
    end
  end

  // Next-state decode from push/pop; flush squashes everything
  always_comb begin
    w_state_nxt = r_state;
    if (flush) begin
      w_state_nxt = ST_EMPTY;
    end else begin
      unique case (r_state)
        ST_EMPTY: if (w_push) w_state_nxt = ST_ONE;
        ST_ONE: begin
          if (w_push && !w_pop)      w_state_nxt = ST_FULL;
          else if (!w_push && w_pop) w_state_nxt = ST_EMPTY;
        end
        ST_FULL:  if (w_pop) w_state_nxt = ST_ONE;
        default:  w_state_nxt = ST_EMPTY;
      endcase
    end
  end

  // Slot controls: where main reloads from and when each slot clears
  always_comb begin
    w_main_load     = 1'b0;
    w_main_clear    = 1'b0;
    w_main_sel_skid = 1'b0;
    w_skid_load     = 1'b0;
    w_skid_clear    = 1'b0;
    if (flush) begin
      w_main_clear = 1'b1;
      w_skid_clear = 1'b1;
    end else begin
      unique case (r_state)
        ST_EMPTY: w_main_load = w_push;
        ST_ONE: begin
          if (w_push && w_pop)       w_main_load  = 1'b1;
          else if (w_push)           w_skid_load  = 1'b1;
          else if (w_pop)            w_main_clear = 1'b1;
        end
        ST_FULL: begin
          if (w_pop) begin
            w_main_load     = 1'b1;
            w_main_sel_skid = 1'b1;
            w_skid_clear    = 1'b1;
          end
        end
        default: begin
          w_main_clear = 1'b1;
          w_skid_clear = 1'b1;
        end
      endcase
    end
  end

  assign w_main_din = w_main_sel_skid ? w_skid_data : in_data;

  pipe_slot #(.W(PAYLOAD_W), .BUBBLE(BUBBLE)) u_main (
    .clk     (clk),
    .reset   (reset),
    .i_load  (w_main_load),
    .i_clear (w_main_clear),
    .i_data  (w_main_din),
    .o_data  (w_main_data),
    .o_valid (w_main_valid)
  );

  pipe_slot #(.W(PAYLOAD_W), .BUBBLE(BUBBLE)) u_skid (
    .clk     (clk),
    .reset   (reset),
    .i_load  (w_skid_load),
    .i_clear (w_skid_clear),
    .i_data  (in_data),
    .o_data  (w_skid_data),
    .o_valid (w_skid_valid)
  );

  assign in_ready  = r_in_ready;
  assign out_valid = w_main_valid;
  assign out_data  = w_main_data;
  assign count     = {1'b0, w_main_valid} + {1'b0, w_skid_valid};

endmodule
